bin2bcd_seq: RTL and testbench

Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. Converts a WIDTH-bit unsigned binary value into DIGITS packed BCD digits over WIDTH clock cycles. A start/ready/done handshake moves data in and out. A sticky overflow flag generalises the single-digit "value ≥ 10" indicator of the combinational 4-bit converter. It sits between binary datapaths (counters, ALU results) and the seven-segment display drivers.

---
 rtl/bin2bcd_seq_if.sv | 32 +++
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 tb/tb_bin2bcd_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master side issues start/bin; the slave side (the converter) answers
// with ready/done and the packed BCD result plus overflow flag.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start,
    output bin,
    input  ready,
    input  done,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin,
    output ready,
    output done,
    output bcd,
    output overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble).
// One input bit is consumed per CONV cycle, so a conversion takes WIDTH
// cycles plus one DONE cycle. Under-sized DIGITS is legal: the digits that
// fit are exact (carries never flow downward) and any bit shifted out of the
// top digit raises a sticky per-conversion overflow flag.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [4*DIGITS-1:0] adj;
  logic                ovf_q, ovf_d;
  logic [CW-1:0]       count_q, count_d;

  logic [4*DIGITS-1:0] bcd_q;
  logic                overflow_q;
  logic                done_q;
  logic                ready_q;

  // State and scratch registers; reset discards any in-flight conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic: load on accepted start, add-3/shift per CONV cycle.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    adj      = digits_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d  = bus.bin;
          digits_d = '0;
          ovf_d    = 1'b0;
          count_d  = CW'(WIDTH);
          state_d  = CONV;
        end
      end
      CONV: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (digits_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = digits_q[4*k +: 4] + 4'd3;
          end
        end
        digits_d = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
        shift_d  = {shift_q[WIDTH-2:0], 1'b0};
        ovf_d    = ovf_q | adj[4*DIGITS-1];
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output registers, loaded from next-state values so that done, bcd and
  // overflow all become visible together in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      ready_q <= (state_d == IDLE);
      done_q  <= (state_d == DONE);
      if (state_d == DONE) begin
        bcd_q      <= digits_d;
        overflow_q <= ovf_d;
      end
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq: three instances cover the default
// 8-bit/3-digit build, an under-sized 8-bit/2-digit build and a wide
// 16-bit/5-digit build. Outputs are sampled 1 time unit after the clock edge.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt_a = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) a_if ();
  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) b_if ();
  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) c_if ();

  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  // Count done pulses of the default instance to catch extra conversions.
  always @(posedge clk) begin
    if (a_if.done === 1'b1) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply_stimulus(input int sel, input logic st, input logic [31:0] value);
    case (sel)
      0: begin a_if.start = st; a_if.bin = value[7:0];  end
      1: begin b_if.start = st; b_if.bin = value[7:0];  end
      default: begin c_if.start = st; c_if.bin = value[15:0]; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return a_if.done;
      1: return b_if.done;
      default: return c_if.done;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      0: return a_if.ready;
      1: return b_if.ready;
      default: return c_if.ready;
    endcase
  endfunction

  function automatic logic [31:0] get_bcd(input int sel);
    case (sel)
      0: return {20'd0, a_if.bcd};
      1: return {24'd0, b_if.bcd};
      default: return {12'd0, c_if.bcd};
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0: return a_if.overflow;
      1: return b_if.overflow;
      default: return c_if.overflow;
    endcase
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance at least one edge, then until done is seen or the budget runs out.
  task automatic wait_done(input int sel, input int budget, output int edges, output logic ready_seen);
    edges = 0;
    ready_seen = 1'b0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (get_done(sel) !== 1'b1 && get_ready(sel) === 1'b1) ready_seen = 1'b1;
    end while (get_done(sel) !== 1'b1 && edges < budget);
    if (get_done(sel) !== 1'b1) check_output("done_timeout", 32'd0, 32'd1);
  endtask

  // Pulse start for one accepted cycle, then wait for the result.
  task automatic convert(input int sel, input logic [31:0] value, input string tag,
                         input logic [31:0] exp_bcd, input logic exp_ovf, input int exp_edges);
    int   edges;
    logic rdy;
    apply_stimulus(sel, 1'b1, value);
    step(1);
    apply_stimulus(sel, 1'b0, 32'd0);
    wait_done(sel, 40, edges, rdy);
    check_output({tag, "_bcd"}, get_bcd(sel), exp_bcd);
    check_output({tag, "_ovf"}, {31'd0, get_ovf(sel)}, {31'd0, exp_ovf});
    check_output({tag, "_latency"}, edges, exp_edges);
    step(1);
  endtask

  initial begin
    int   edges;
    int   cnt0;
    logic rdy;

    apply_stimulus(0, 1'b0, 32'd0);
    apply_stimulus(1, 1'b0, 32'd0);
    apply_stimulus(2, 1'b0, 32'd0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;

    check_output("reset_ready", {31'd0, a_if.ready}, 32'd1);
    check_output("reset_done",  {31'd0, a_if.done},  32'd0);
    check_output("reset_bcd",   get_bcd(0),          32'h000);
    check_output("reset_ovf",   {31'd0, a_if.overflow}, 32'd0);

    // Full scale 255: done after 8 further edges, ready low throughout.
    apply_stimulus(0, 1'b1, 32'd255);
    step(1);
    apply_stimulus(0, 1'b0, 32'd0);
    check_output("full_ready_c1", {31'd0, a_if.ready}, 32'd0);
    wait_done(0, 40, edges, rdy);
    check_output("full_latency", edges, 32'd8);
    check_output("full_ready_busy", {31'd0, rdy}, 32'd0);
    check_output("full_ready_done", {31'd0, a_if.ready}, 32'd0);
    check_output("full_bcd", get_bcd(0), 32'h255);
    check_output("full_ovf", {31'd0, a_if.overflow}, 32'd0);
    step(1);
    check_output("full_done_pulse", {31'd0, a_if.done}, 32'd0);
    check_output("full_ready_after", {31'd0, a_if.ready}, 32'd1);

    convert(0, 32'd0,   "zero", 32'h000, 1'b0, 8);
    convert(0, 32'd100, "hund", 32'h100, 1'b0, 8);
    convert(0, 32'd9,   "nine", 32'h009, 1'b0, 8);

    // Busy start: bin=77 offered during CONV cycle 4 must be ignored.
    cnt0 = done_cnt_a;
    apply_stimulus(0, 1'b1, 32'd123);
    step(1);
    apply_stimulus(0, 1'b0, 32'd0);
    step(3);
    apply_stimulus(0, 1'b1, 32'd77);
    step(1);
    apply_stimulus(0, 1'b0, 32'd0);
    wait_done(0, 40, edges, rdy);
    check_output("busy_bcd", get_bcd(0), 32'h123);
    step(12);
    check_output("busy_done_count", done_cnt_a - cnt0, 32'd1);
    check_output("busy_bcd_hold", get_bcd(0), 32'h123);

    // Reset during CONV cycle 5 of a conversion of 200.
    apply_stimulus(0, 1'b1, 32'd200);
    step(1);
    apply_stimulus(0, 1'b0, 32'd0);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_output("rst_ready", {31'd0, a_if.ready}, 32'd1);
    check_output("rst_bcd",   get_bcd(0),          32'h000);
    check_output("rst_ovf",   {31'd0, a_if.overflow}, 32'd0);
    check_output("rst_done",  {31'd0, a_if.done},  32'd0);
    cnt0 = done_cnt_a;
    step(12);
    check_output("rst_no_done", done_cnt_a - cnt0, 32'd0);
    convert(0, 32'd58, "after_rst", 32'h058, 1'b0, 8);

    // Two-digit build: truncation and per-conversion overflow.
    convert(1, 32'd99,  "d2_99",  32'h99, 1'b0, 8);
    convert(1, 32'd200, "d2_200", 32'h00, 1'b1, 8);
    convert(1, 32'd47,  "d2_47",  32'h47, 1'b0, 8);

    // Wide build with start held high: back-to-back conversions.
    apply_stimulus(2, 1'b1, 32'd65535);
    step(1);
    apply_stimulus(2, 1'b1, 32'd1234);
    wait_done(2, 40, edges, rdy);
    check_output("wide_latency", edges, 32'd16);
    check_output("wide_bcd0", get_bcd(2), 32'h65535);
    wait_done(2, 40, edges, rdy);
    check_output("wide_spacing", edges, 32'd18);
    check_output("wide_bcd1", get_bcd(2), 32'h01234);
    apply_stimulus(2, 1'b0, 32'd0);
    step(2);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
